// File: rtl/seq_detector_n.sv
// Serial pattern detector: runtime-loadable PAT_W-bit pattern, optional overlap,
// Moore or Mealy match output, qualified input and a saturating match counter.
module seq_detector_n #(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1,
  parameter int MEALY   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           x,
  input  logic                           x_valid,
  input  logic [PAT_W-1:0]               pattern,
  input  logic                           load_pat,
  input  logic                           clr_count,
  output logic [$clog2(PAT_W+1)-1:0]     fill,
  output logic                           y,
  output logic [CNT_W-1:0]               match_count,
  output logic                           count_sat
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] shifted;
  logic [FW-1:0]    next_fill;
  logic             match_acc;

  assign shifted   = {hist_q[PAT_W-2:0], x};
  assign next_fill = (fill_q == FULL) ? FULL : fill_q + 1'b1;
  // A bit presented alongside load_pat is discarded, so it can never complete a match.
  assign match_acc = x_valid & ~load_pat & (next_fill == FULL) & (shifted == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    cnt_d  = cnt_q;
    if (load_pat) begin
      pat_d  = pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (x_valid) begin
      y_d = match_acc;
      if (match_acc && (OVERLAP == 0)) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = shifted;
        fill_d = next_fill;
      end
    end
    if (clr_count) begin
      cnt_d = '0;
    end else if (match_acc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fill        = fill_q;
  assign y           = (MEALY != 0) ? (match_acc & ~reset) : y_q;
  assign match_count = cnt_q;
  assign count_sat   = (cnt_q == {CNT_W{1'b1}});

endmodule

// File: tb/tb_seq_detector_n.sv
// Bench for seq_detector_n: four configurations share one stimulus stream and
// are compared against a behavioural model through a scoreboard queue.
module tb_seq_detector_n;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic [3:0] pattern = 4'b0;
  logic       load_pat = 1'b0;
  logic       clr_count = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] fill_w [4];
  logic       y_w    [4];
  logic [7:0] cnt_w  [4];
  logic       sat_w  [4];
  logic [2:0] cnt_d3;

  // 0: overlap Moore, 1: no-overlap Moore, 2: overlap Mealy, 3: overlap Moore 3-bit counter
  seq_detector_n #(.PAT_W(4), .CNT_W(8), .OVERLAP(1), .MEALY(0)) u_a (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pattern(pattern),
    .load_pat(load_pat), .clr_count(clr_count), .fill(fill_w[0]), .y(y_w[0]),
    .match_count(cnt_w[0]), .count_sat(sat_w[0]));
  seq_detector_n #(.PAT_W(4), .CNT_W(8), .OVERLAP(0), .MEALY(0)) u_b (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pattern(pattern),
    .load_pat(load_pat), .clr_count(clr_count), .fill(fill_w[1]), .y(y_w[1]),
    .match_count(cnt_w[1]), .count_sat(sat_w[1]));
  seq_detector_n #(.PAT_W(4), .CNT_W(8), .OVERLAP(1), .MEALY(1)) u_c (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pattern(pattern),
    .load_pat(load_pat), .clr_count(clr_count), .fill(fill_w[2]), .y(y_w[2]),
    .match_count(cnt_w[2]), .count_sat(sat_w[2]));
  seq_detector_n #(.PAT_W(4), .CNT_W(3), .OVERLAP(1), .MEALY(0)) u_d (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pattern(pattern),
    .load_pat(load_pat), .clr_count(clr_count), .fill(fill_w[3]), .y(y_w[3]),
    .match_count(cnt_d3), .count_sat(sat_w[3]));
  assign cnt_w[3] = {5'b0, cnt_d3};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model state, one slot per configuration
  int cfg_ov [4] = '{1, 0, 1, 1};
  int cfg_me [4] = '{0, 0, 1, 0};
  int cfg_cw [4] = '{8, 8, 8, 3};
  int m_hist [4];
  int m_fill [4];
  int m_cnt  [4];
  int m_y    [4];
  int m_pat;

  typedef struct packed {
    logic [2:0] fill;
    logic       y;
    logic [7:0] cnt;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  logic mealy_q[$];

  task automatic model(input logic xi, vi, ldi, input logic [3:0] pi, input logic clri, rsti);
    int nf, sh, cmax;
    logic hit;
    for (int i = 0; i < 4; i++) begin
      cmax = (1 << cfg_cw[i]) - 1;
      if (rsti) begin
        m_hist[i] = 0; m_fill[i] = 0; m_cnt[i] = 0; m_y[i] = 0;
        if (i == 2) mealy_q.push_back(1'b0);
      end else begin
        nf  = (m_fill[i] + 1 > 4) ? 4 : m_fill[i] + 1;
        sh  = ((m_hist[i] << 1) | int'(xi)) & 15;
        hit = vi && !ldi && (nf == 4) && (sh == m_pat);
        if (i == 2) mealy_q.push_back(hit);
        if (clri) m_cnt[i] = 0;
        else if (hit && m_cnt[i] != cmax) m_cnt[i] = m_cnt[i] + 1;
        m_y[i] = int'(hit);
        if (ldi) begin
          m_hist[i] = 0; m_fill[i] = 0;
        end else if (vi) begin
          if (hit && cfg_ov[i] == 0) begin
            m_hist[i] = 0; m_fill[i] = 0;
          end else begin
            m_hist[i] = sh; m_fill[i] = nf;
          end
        end
      end
      exp_q.push_back('{fill: m_fill[i][2:0], y: m_y[i][0], cnt: m_cnt[i][7:0],
                        sat: (m_cnt[i] == cmax)});
    end
    if (rsti) m_pat = 0;
    else if (ldi) m_pat = int'(pi);
  endtask

  task automatic step(input logic xi, vi, ldi, input logic [3:0] pi, input logic clri, rsti);
    exp_t e;
    logic em;
    @(negedge clk);
    x = xi; x_valid = vi; load_pat = ldi; pattern = pi; clr_count = clri; reset = rsti;
    model(xi, vi, ldi, pi, clri, rsti);
    #1;
    em = mealy_q.pop_front();
    check("mealy_y", {31'b0, y_w[2]}, {31'b0, em});
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      check($sformatf("fill%0d", i), {29'b0, fill_w[i]}, {29'b0, e.fill});
      if (cfg_me[i] == 0) check($sformatf("y%0d", i), {31'b0, y_w[i]}, {31'b0, e.y});
      check($sformatf("cnt%0d", i), {24'b0, cnt_w[i]}, {24'b0, e.cnt});
      check($sformatf("sat%0d", i), {31'b0, sat_w[i]}, {31'b0, e.sat});
    end
  endtask

  task automatic bit_in(input logic xi);
    step(xi, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
  endtask

  task automatic do_load(input logic [3:0] p);
    step(1'b0, 1'b0, 1'b1, p, 1'b0, 1'b0);
  endtask

  task automatic gap();
    step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
  endtask

  logic [6:0] s1 = 7'b1011011;
  logic [3:0] s4 = 4'b0110;

  initial begin
    // Reset state
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("rst_fill", {29'b0, fill_w[i]}, 32'd0);
      check("rst_cnt", {24'b0, cnt_w[i]}, 32'd0);
    end

    // Pattern 1011 on 1,0,1,1,0,1,1
    do_load(4'b1011);
    for (int k = 6; k >= 0; k--) bit_in(s1[k]);
    check("ov_cnt", {24'b0, cnt_w[0]}, 32'd2);
    check("ov_fill", {29'b0, fill_w[0]}, 32'd4);
    check("nov_cnt", {24'b0, cnt_w[1]}, 32'd1);
    check("nov_fill", {29'b0, fill_w[1]}, 32'd3);

    // Valid gaps between bits 2 and 3
    do_reset();
    do_load(4'b1011);
    bit_in(1'b1); bit_in(1'b0); gap(); gap(); bit_in(1'b1); bit_in(1'b1);
    check("gap_cnt", {24'b0, cnt_w[2]}, 32'd1);
    bit_in(1'b0);

    // Pattern 1111 on eleven 1s, clear coinciding with the last
    do_reset();
    do_load(4'b1111);
    for (int k = 0; k < 10; k++) bit_in(1'b1);
    check("sat_cnt", {24'b0, cnt_w[3]}, 32'd7);
    check("sat_flag", {31'b0, sat_w[3]}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 4'b0, 1'b1, 1'b0);
    check("clr_cnt", {24'b0, cnt_w[3]}, 32'd0);

    // Reload mid-stream discards history
    do_reset();
    do_load(4'b1011);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    check("ld_fill", {29'b0, fill_w[0]}, 32'd0);
    for (int k = 3; k >= 0; k--) bit_in(s4[k]);
    check("ld_cnt", {24'b0, cnt_w[0]}, 32'd1);

    // Reset mid-pattern
    do_load(4'b1011);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
    check("mid_rst_y", {31'b0, y_w[0]}, 32'd0);
    bit_in(1'b1);
    check("mid_rst_fill", {29'b0, fill_w[0]}, 32'd1);

    // Random traffic with occasional reload, clear and reset
    do_reset();
    do_load(4'b0101);
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
